// File: rtl/cf_util_fifo_reader_if.sv
// Bus bundle between the FIFO read port, the reader adapter and the stream consumer.
// Stream handshake: a word transfers on a rising edge where m_valid && m_ready; m_valid never waits on m_ready.
interface cf_util_fifo_reader_if #(
  parameter int DW = 8
);
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [1:0]    occ;

  modport master (
    input  flush, fifo_empty, fifo_rdata, m_ready,
    output fifo_rd, m_valid, m_data, m_last, occ
  );

  modport slave (
    output flush, fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd, m_valid, m_data, m_last, occ
  );
endinterface

// File: rtl/cf_util_fifo_reader.sv
// FWFT FIFO to valid/ready stream adapter: two-entry registered output buffer
// with fixed-length packet framing on m_last.
module cf_util_fifo_reader #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cf_util_fifo_reader_if.master  bus
);
  localparam int              CW        = $clog2(PKT_LEN + 1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(PKT_LEN - 1);

  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;
  logic          take;
  logic [1:0]    slot;

  // pop never looks at m_ready, so occ can reach 2 and absorb one cycle of backpressure.
  assign take = (occ_q != 2'd0) && bus.m_ready;
  assign pop  = !bus.fifo_empty && (occ_q != 2'd2) && !bus.flush && !rst;

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    slot   = occ_q;
    if (take) begin
      buf0_d = buf1_q;
      slot   = occ_q - 2'd1;
      cnt_d  = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
    end
    // The popped word lands in the lowest slot left free after the shift.
    if (pop) begin
      if (slot == 2'd0) begin
        buf0_d = bus.fifo_rdata;
      end else begin
        buf1_d = bus.fifo_rdata;
      end
    end
    occ_d = occ_q + {1'b0, pop} - {1'b0, take};
    if (bus.flush) begin
      occ_d = 2'd0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.fifo_rd = pop;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = buf0_q;
  assign bus.m_last  = (occ_q != 2'd0) && (cnt_q == LAST_BEAT);
  assign bus.occ     = occ_q;
endmodule
